// File: rtl/clock_gen_rst_seq.sv
// Post-PLL reset sequencer: synchronises and filters the PLL lock flag, then
// releases NUM_RST downstream resets one after another with a fixed stagger.
// Lock loss restarts the whole sequence and is counted; software may request
// a re-run of HOLD/RELEASE while lock is held.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all resets asserted, waiting for filtered lock
// HOLD      | lock accepted, all resets held for HOLD_CYCLES
// RELEASE   | channels released in index order, STAGGER cycles apart
// RUN       | all resets released, o_ready high
module clock_gen_rst_seq #(
    parameter int NUM_RST     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 16,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_locked,
    input  logic                  i_soft_rst,
    output logic [NUM_RST-1:0]    o_rst,
    output logic                  o_ready,
    output logic                  o_lock_loss,
    output logic [LOSS_CNT_W-1:0] o_loss_count
);

    localparam int FLT_W   = $clog2(FILTER + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_RST + 1);

    localparam logic [FLT_W-1:0] FLT_LOAD  = FLT_W'(FILTER - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LOAD = TMR_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_RST);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic [FLT_W-1:0]       flt_q;
    logic                   lock_ok;

    state_t                 state_q,  state_d;
    logic [TMR_W-1:0]       tmr_q,    tmr_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [NUM_RST-1:0]     rst_q,    rst_d;
    logic                   ready_q,  ready_d;
    logic                   loss_q,   loss_d;
    logic [LOSS_CNT_W-1:0]  count_q,  count_d;

    // Shift the asynchronous lock flag through the synchroniser chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Down-counter of remaining high cycles; reloaded on every low so that
    // chatter never accumulates toward acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flt_q <= '0;
        end else if (!lk_s) begin
            flt_q <= FLT_LOAD;
        end else if (flt_q != '0) begin
            flt_q <= flt_q - 1'b1;
        end
    end

    // Filtered lock as seen by the FSM. It is the value the filtered flag
    // takes at this edge, so the FSM moves in the same cycle the flag rises
    // and reacts to a low lk_s immediately (no filtering on loss).
    assign lock_ok = lk_s && (flt_q == '0);

    // Sequencer state, timer, channel index and output flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WAIT_LOCK;
            tmr_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            loss_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
            count_q <= count_d;
        end
    end

    // Next-state and next-output logic; lock loss outranks soft reset.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        loss_d  = 1'b0;
        count_d = count_q;

        if ((state_q != WAIT_LOCK) && !lock_ok) begin
            state_d = WAIT_LOCK;
            tmr_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            loss_d  = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end else if ((state_q != WAIT_LOCK) && i_soft_rst) begin
            state_d = HOLD;
            tmr_d   = HOLD_LOAD;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    if (lock_ok) begin
                        state_d = HOLD;
                        tmr_d   = HOLD_LOAD;
                        idx_d   = '0;
                    end
                end
                HOLD: begin
                    if (tmr_q == '0) begin
                        state_d  = RELEASE;
                        rst_d[0] = 1'b0;
                        tmr_d    = STAG_LOAD;
                        idx_d    = IDX_FIRST;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (idx_q == IDX_DONE) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else if (tmr_q == '0) begin
                        for (int k = 0; k < NUM_RST; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                rst_d[k] = 1'b0;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        tmr_d = STAG_LOAD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                RUN: begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign o_rst        = rst_q;
    assign o_ready      = ready_q;
    assign o_lock_loss  = loss_q;
    assign o_loss_count = count_q;

endmodule
